lcd_cmd_sequencer: RTL and testbench
====================================

Name: lcd_cmd_sequencer

Overview:
- Upstream feeder for the LCD controller custom instruction: drives its data_a/data_b/start inputs and consumes its done pulse.
- After reset, it replays the fixed HD44780 init sequence, then drains a FIFO of rs/byte commands written by the processor side.
- Issues one command at a time, waiting for done. A watchdog keeps the sequencer from hanging if done never arrives.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of 2, ≥2.
- TIMEOUT_CYCLES, 300000, max cycles waiting for lcd_done before abandoning a command; must exceed controller busy+end time (~200002).

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- wr_valid  in  1  command write request
- wr_ready  out  1  FIFO not full; write accepted on wr_valid&&wr_ready at posedge
- wr_rs  in  1  0=instruction, 1=data
- wr_data  in  8  LCD byte
- lcd_a  out  32  to controller data_a; {31'b0, rs}
- lcd_b  out  32  to controller data_b; {24'b0, byte}
- lcd_start  out  1  one-cycle start pulse to controller
- lcd_done  in  1  controller done pulse
- init_done  out  1  init sequence finished
- busy  out  1  state!=IDLE or FIFO non-empty
- timeout_err  out  1  sticky; a command timed out

Behaviour:
- Single clock domain. reset_n sampled only at posedge; reset_n=0 overrides everything.
- Reset values: lcd_a=0, lcd_b=0, lcd_start=0, init_done=0, timeout_err=0, FIFO empty, init index=0, timeout counter=0, state=INIT_ISSUE.
- wr_ready=!full is combinational. busy is combinational, so it is 1 during and right after reset. All other outputs are registered.
- The controller's clock_en is tied high at top level. Its active-high reset is driven by ~reset_n.
- FIFO:
  - Read/write pointers carry an extra wrap bit; full = MSBs differ and indices equal.
  - Pointers wrap modulo FIFO_DEPTH.
  - A write while full is ignored (ready=0).
  - A push and pop in the same cycle are both performed; count is unchanged.
  - No bypass: an entry becomes visible the cycle after its write.
  - Writes are accepted during init and queue behind it.
- FSM states, INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT:
  - INIT_ISSUE: load lcd_a/lcd_b from INIT_ROM[idx]; lcd_start=1 for this one cycle; clear the timeout counter; go to INIT_WAIT.
  - INIT_WAIT:
    - On lcd_done: idx+1. If idx was INIT_LEN-1, set init_done=1 and go to IDLE; else go to INIT_ISSUE.
    - On counter==TIMEOUT_CYCLES-1: set timeout_err and advance exactly as on done.
  - IDLE: if FIFO non-empty, pop the head into lcd_a/lcd_b and go to ISSUE.
  - ISSUE: lcd_start=1 for this one cycle; clear the counter; go to WAIT.
  - WAIT: on lcd_done go to IDLE; on timeout set timeout_err and go to IDLE (the command is dropped).
- lcd_done is honoured only in INIT_WAIT/WAIT; it is ignored in all other states. If done and timeout occur in the same cycle, done wins and timeout_err is not set.
- Latency: a write accepted at edge t into an empty FIFO with the FSM in IDLE gives lcd_start high in cycle t+2 (decision at t+1, ISSUE at t+2). The next command's lcd_start comes 2 cycles after the lcd_done cycle.
- lcd_a/lcd_b hold their values from ISSUE until the next pop or init load.
- lcd_start is never asserted in the cycle lcd_done is high, because the controller is in its idle state only after done.
- Reset mid-command: all state returns to reset values and the init sequence restarts from idx 0. Queued FIFO contents are lost.
- Timeout counter is 32 bits, increments only in the WAIT states, and saturates at TIMEOUT_CYCLES-1.

Decomposition:
- Package lcd_pkg holds:
  - state encoding localparams;
  - INIT_LEN=4;
  - INIT_ROM: {rs,byte} = {0,8'h38}, {0,8'h0C}, {0,8'h06}, {0,8'h01};
  - RS_INSTR=0, RS_DATA=1.
- One sub-module: lcd_cmd_fifo, a parameterised 9-bit synchronous FIFO with push/pop/full/empty.

Test Plan:
- Reset release with a controller model that returns done 5 cycles after start → four start pulses with lcd_b=0x38, 0x0C, 0x06, 0x01 and lcd_a=0. init_done rises 1 cycle after the 4th done; busy=0 afterwards.
- After init, write (rs=1, 0x41) at edge t → lcd_start in cycle t+2 with lcd_a=1, lcd_b=0x41. After done, busy=0.
- With the model stalled, write 8 entries → wr_ready=0 after the 8th. A 9th write is ignored. Release the model → exactly 8 starts, in order, data intact across pointer wrap.
- TIMEOUT_CYCLES=20, model never asserts done → timeout_err=1 exactly 20 cycles after the first start. The sequencer advances through all init entries and stays sticky until reset.
- Assert reset_n=0 for 1 cycle during WAIT of a queued command → outputs return to reset values and FIFO empties. The next start has lcd_b=0x38.
- Spurious lcd_done pulse in IDLE with FIFO empty → no state change, no lcd_start, timeout_err unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: state encoding, command
// layout and the fixed HD44780 power-up instruction list.
package lcd_pkg;

  localparam logic [2:0] S_INIT_ISSUE = 3'd0;
  localparam logic [2:0] S_INIT_WAIT  = 3'd1;
  localparam logic [2:0] S_IDLE       = 3'd2;
  localparam logic [2:0] S_ISSUE      = 3'd3;
  localparam logic [2:0] S_WAIT       = 3'd4;

  typedef enum logic [2:0] {
    INIT_ISSUE = S_INIT_ISSUE,
    INIT_WAIT  = S_INIT_WAIT,
    IDLE       = S_IDLE,
    ISSUE      = S_ISSUE,
    WAIT       = S_WAIT
  } state_t;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  // A command is {rs, byte}; rs sits in the MSB.
  localparam int CMD_W    = 9;
  localparam int INIT_LEN = 4;

  // Function set 8-bit/2-line, display on, entry mode increment, clear.
  localparam logic [CMD_W-1:0] INIT_ROM [INIT_LEN] = '{
    {RS_INSTR, 8'h38},
    {RS_INSTR, 8'h0C},
    {RS_INSTR, 8'h06},
    {RS_INSTR, 8'h01}
  };

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command FIFO; pointers carry a wrap bit so full and empty
// can be told apart when the indices match.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Feeds the LCD controller custom instruction: replays the HD44780 init list,
// then drains queued commands one at a time with a watchdog on lcd_done.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 300000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_rs,
  input  logic [7:0]  wr_data,
  output logic [31:0] lcd_a,
  output logic [31:0] lcd_b,
  output logic        lcd_start,
  input  logic        lcd_done,
  output logic        init_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam int IDX_W = $clog2(INIT_LEN);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] init_idx;
  logic [31:0]      wait_cnt;
  logic             cur_rs;
  logic [7:0]       cur_byte;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_head;

  logic             expired;
  logic             idx_last;
  logic             load_init;
  logic             clear_cnt;
  logic             count_up;
  logic             finish;
  logic             set_timeout;
  logic             advance_init;
  logic             start_nxt;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (wr_valid),
    .push_data ({wr_rs, wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign expired  = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign idx_last = (init_idx == IDX_W'(INIT_LEN - 1));
  assign wr_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign lcd_a    = {31'b0, cur_rs};
  assign lcd_b    = {24'b0, cur_byte};

  always_ff @(posedge clock) begin
    if (!reset_n) state <= INIT_ISSUE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT_ISSUE: state_nxt = INIT_WAIT;
      INIT_WAIT:  if (lcd_done || expired) state_nxt = idx_last ? IDLE : INIT_ISSUE;
      IDLE:       if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT;
      WAIT:       if (lcd_done || expired) state_nxt = IDLE;
      default:    state_nxt = INIT_ISSUE;
    endcase
  end

  // The start pulse is registered off the load decision, so it lines up with
  // the freshly loaded lcd_a/lcd_b on the following cycle.
  always_comb begin
    load_init    = (state == INIT_ISSUE);
    fifo_pop     = (state == IDLE) && !fifo_empty;
    clear_cnt    = (state == INIT_ISSUE) || (state == ISSUE);
    count_up     = (state == INIT_WAIT) || (state == WAIT);
    finish       = count_up && (lcd_done || expired);
    set_timeout  = count_up && expired && !lcd_done;
    advance_init = (state == INIT_WAIT) && finish;
    start_nxt    = load_init || fifo_pop;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lcd_start   <= 1'b0;
      cur_rs      <= 1'b0;
      cur_byte    <= 8'h00;
      init_idx    <= '0;
      wait_cnt    <= '0;
      init_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      lcd_start <= start_nxt;
      if (load_init)     {cur_rs, cur_byte} <= INIT_ROM[init_idx];
      else if (fifo_pop) {cur_rs, cur_byte} <= fifo_head;
      if (clear_cnt)                wait_cnt <= '0;
      else if (count_up && !expired) wait_cnt <= wait_cnt + 32'd1;
      if (advance_init) init_idx <= init_idx + 1'b1;
      if (advance_init && idx_last) init_done <= 1'b1;
      if (set_timeout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: a simple controller model answers each start,
// and every start seen is compared with the order the sequencer should follow.
module tb_lcd_cmd_sequencer;

  localparam int TO    = 20;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_rs = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        lcd_done = 1'b0;
  logic        wr_ready;
  logic [31:0] lcd_a;
  logic [31:0] lcd_b;
  logic        lcd_start;
  logic        init_done;
  logic        busy;
  logic        timeout_err;

  lcd_cmd_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_rs       (wr_rs),
    .wr_data     (wr_data),
    .lcd_a       (lcd_a),
    .lcd_b       (lcd_b),
    .lcd_start   (lcd_start),
    .lcd_done    (lcd_done),
    .init_done   (init_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          at;
  } start_t;

  start_t      obs_q[$];
  int          done_q[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  init_bytes [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  int resp_delay = 5;
  bit hold = 1'b0;
  bit dead = 1'b0;
  int spur_req = 0;
  int spur_ack = 0;
  bit pending = 1'b0;
  int remain = 0;

  // Controller stand-in: logs each start and answers resp_delay cycles later.
  always @(negedge clock) begin
    lcd_done = 1'b0;
    if (!reset_n) begin
      pending = 1'b0;
      remain  = 0;
    end else begin
      if (pending) begin
        if (remain > 0) remain--;
        if (remain == 0 && !hold && !dead) begin
          lcd_done = 1'b1;
          pending  = 1'b0;
          done_q.push_back(cyc);
        end
      end
      if (lcd_start) begin
        obs_q.push_back('{lcd_a, lcd_b, cyc});
        pending = 1'b1;
        remain  = resp_delay;
      end
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        lcd_done = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_starts(input int n, input int budget, output bit ok);
    int spent = 0;
    while (obs_q.size() < n && spent < budget) begin
      tick(1);
      spent++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    int spent = 0;
    while (done_q.size() < n && spent < budget) begin
      tick(1);
      spent++;
    end
    ok = (done_q.size() >= n);
  endtask

  task automatic write_cmd(input logic rs, input logic [7:0] d, output int wcyc);
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    wcyc     = cyc;
    tick(1);
    wr_valid = 1'b0;
  endtask

  task automatic clear_logs();
    obs_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] got [7];
    logic [31:0] want [7];
    string       name [7];
    reset_n = 1'b0;
    tick(3);
    got  = '{32'(lcd_start), lcd_a, lcd_b, 32'(init_done), 32'(timeout_err), 32'(busy), 32'(wr_ready)};
    want = '{0, 0, 0, 0, 0, 1, 1};
    name = '{"lcd_start", "lcd_a", "lcd_b", "init_done", "timeout_err", "busy", "wr_ready"};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== want[i])
        $display("[TB] FAIL reset_%s: got %h expected %h", name[i], got[i], want[i]);
      else passed++;
    end
  endtask

  task automatic test_init();
    bit ok;
    int n = 0;
    int rise;
    int want_rise;
    resp_delay = 5;
    clear_logs();
    reset_n = 1'b1;
    wait_starts(4, 200, ok);
    checks++;
    if (!ok) $display("[TB] FAIL init_starts: got %0d starts expected 4", obs_q.size());
    else passed++;
    while (!init_done && n < 100) begin
      tick(1);
      n++;
    end
    rise = cyc;
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].a !== 32'h0 || obs_q[k].b !== {24'h0, init_bytes[k]})
        $display("[TB] FAIL init_cmd%0d: got a=%h b=%h expected a=0 b=%h", k, obs_q[k].a, obs_q[k].b, init_bytes[k]);
      else passed++;
    end
    for (int k = 0; k < 3 && k + 1 < obs_q.size() && k < done_q.size(); k++) begin
      checks++;
      if (obs_q[k+1].at !== done_q[k] + 2)
        $display("[TB] FAIL init_gap%0d: start at %0d expected %0d", k, obs_q[k+1].at, done_q[k] + 2);
      else passed++;
    end
    want_rise = (done_q.size() >= 4) ? done_q[3] + 1 : -1;
    checks++;
    if (!init_done || rise !== want_rise)
      $display("[TB] FAIL init_done_rise: rose at %0d expected %0d", rise, want_rise);
    else passed++;
    tick(2);
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL init_busy: got %b expected 0", busy);
    else passed++;
    clear_logs();
  endtask

  task automatic test_single_cmd();
    bit ok;
    int wcyc;
    clear_logs();
    resp_delay = 4;
    write_cmd(1'b1, 8'h41, wcyc);
    wait_starts(1, 20, ok);
    checks++;
    if (!ok || obs_q[0].a !== 32'h1 || obs_q[0].b !== 32'h41 || obs_q[0].at !== wcyc + 2)
      $display("[TB] FAIL single_cmd: got start=%0d a=%h b=%h at=%0d expected a=1 b=41 at=%0d",
               obs_q.size(), ok ? obs_q[0].a : 32'hx, ok ? obs_q[0].b : 32'hx, ok ? obs_q[0].at : -1, wcyc + 2);
    else passed++;
    wait_dones(1, 30, ok);
    tick(1);
    checks++;
    if (!ok || busy !== 1'b0) $display("[TB] FAIL single_busy: done=%b busy=%b expected done=1 busy=0", ok, busy);
    else passed++;
    clear_logs();
  endtask

  task automatic test_spurious_done();
    bit   ok;
    int   wcyc;
    logic te = timeout_err;
    clear_logs();
    spur_req++;
    tick(6);
    checks++;
    if (obs_q.size() != 0 || busy !== 1'b0 || timeout_err !== te || init_done !== 1'b1)
      $display("[TB] FAIL spurious_idle: starts=%0d busy=%b timeout_err=%b init_done=%b expected 0/0/%b/1",
               obs_q.size(), busy, timeout_err, te, init_done);
    else passed++;
    write_cmd(1'b0, 8'hC0, wcyc);
    wait_starts(1, 20, ok);
    checks++;
    if (!ok || obs_q[0].b !== 32'hC0 || obs_q[0].at !== wcyc + 2)
      $display("[TB] FAIL spurious_follow: got b=%h at=%0d expected b=c0 at=%0d",
               ok ? obs_q[0].b : 32'hx, ok ? obs_q[0].at : -1, wcyc + 2);
    else passed++;
    wait_dones(1, 30, ok);
    tick(2);
    clear_logs();
  endtask

  task automatic test_back_to_back_full();
    bit         ok;
    int         wcyc;
    logic [8:0] c;
    clear_logs();
    hold       = 1'b1;
    resp_delay = 2;
    c = 9'($urandom);
    exp_q.push_back(c);
    write_cmd(c[8], c[7:0], wcyc);
    wait_starts(1, 20, ok);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (wr_ready !== 1'b1) $display("[TB] FAIL full_ready%0d: got %b expected 1", i, wr_ready);
      else passed++;
      c = 9'($urandom);
      exp_q.push_back(c);
      write_cmd(c[8], c[7:0], wcyc);
    end
    checks++;
    if (wr_ready !== 1'b0) $display("[TB] FAIL full_ready_after8: got %b expected 0", wr_ready);
    else passed++;
    write_cmd(1'b1, 8'hEE, wcyc);
    checks++;
    if (wr_ready !== 1'b0) $display("[TB] FAIL full_ready_after9: got %b expected 0", wr_ready);
    else passed++;
    hold = 1'b0;
    wait_starts(DEPTH + 1, 300, ok);
    tick(40);
    checks++;
    if (obs_q.size() != DEPTH + 1 || busy !== 1'b0)
      $display("[TB] FAIL full_count: got %0d starts busy=%b expected %0d starts busy=0", obs_q.size(), busy, DEPTH + 1);
    else passed++;
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].a !== {31'b0, exp_q[k][8]} || obs_q[k].b !== {24'b0, exp_q[k][7:0]})
        $display("[TB] FAIL full_cmd%0d: got a=%h b=%h expected rs=%b byte=%h", k, obs_q[k].a, obs_q[k].b, exp_q[k][8], exp_q[k][7:0]);
      else passed++;
    end
    clear_logs();
  endtask

  task automatic test_random_stream();
    bit         ok;
    int         wcyc;
    int         n;
    logic [8:0] c;
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      tick($urandom_range(0, 3));
      resp_delay = $urandom_range(1, 8);
      n = 0;
      while (!wr_ready && n < 100) begin
        tick(1);
        n++;
      end
      c = 9'($urandom);
      if (wr_ready) exp_q.push_back(c);
      write_cmd(c[8], c[7:0], wcyc);
    end
    wait_starts(16, 600, ok);
    tick(20);
    checks++;
    if (obs_q.size() != 16 || timeout_err !== 1'b0)
      $display("[TB] FAIL random_count: got %0d starts timeout_err=%b expected 16 starts timeout_err=0", obs_q.size(), timeout_err);
    else passed++;
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].a !== {31'b0, exp_q[k][8]} || obs_q[k].b !== {24'b0, exp_q[k][7:0]})
        $display("[TB] FAIL random_cmd%0d: got a=%h b=%h expected rs=%b byte=%h", k, obs_q[k].a, obs_q[k].b, exp_q[k][8], exp_q[k][7:0]);
      else passed++;
    end
    clear_logs();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int wcyc;
    clear_logs();
    hold = 1'b1;
    write_cmd(1'b1, 8'h5A, wcyc);
    write_cmd(1'b1, 8'hA5, wcyc);
    wait_starts(1, 20, ok);
    tick(2);
    reset_n = 1'b0;
    tick(1);
    checks++;
    if (lcd_start !== 1'b0 || lcd_a !== 32'h0 || lcd_b !== 32'h0 || init_done !== 1'b0 ||
        timeout_err !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b1)
      $display("[TB] FAIL midreset_outputs: start=%b a=%h b=%h init_done=%b terr=%b busy=%b ready=%b expected 0/0/0/0/0/1/1",
               lcd_start, lcd_a, lcd_b, init_done, timeout_err, busy, wr_ready);
    else passed++;
    hold       = 1'b0;
    resp_delay = 3;
    clear_logs();
    reset_n = 1'b1;
    wait_starts(4, 200, ok);
    checks++;
    if (!ok || obs_q[0].a !== 32'h0 || obs_q[0].b !== 32'h38)
      $display("[TB] FAIL midreset_first: got a=%h b=%h expected a=0 b=38", ok ? obs_q[0].a : 32'hx, ok ? obs_q[0].b : 32'hx);
    else passed++;
    tick(30);
    checks++;
    if (obs_q.size() != 4 || busy !== 1'b0 || init_done !== 1'b1)
      $display("[TB] FAIL midreset_flushed: got %0d starts busy=%b init_done=%b expected 4/0/1", obs_q.size(), busy, init_done);
    else passed++;
    clear_logs();
  endtask

  task automatic test_timeout();
    bit ok;
    int c;
    int n = 0;
    dead    = 1'b1;
    reset_n = 1'b0;
    tick(2);
    clear_logs();
    reset_n = 1'b1;
    wait_starts(1, 10, ok);
    c = ok ? obs_q[0].at : cyc;
    while (cyc < c + TO - 1) tick(1);
    checks++;
    if (timeout_err !== 1'b0) $display("[TB] FAIL timeout_early: got %b expected 0 at cycle start+%0d", timeout_err, TO - 1);
    else passed++;
    tick(1);
    checks++;
    if (timeout_err !== 1'b1) $display("[TB] FAIL timeout_onset: got %b expected 1 at cycle start+%0d", timeout_err, TO);
    else passed++;
    wait_starts(4, 200, ok);
    for (int k = 0; k < 3 && k + 1 < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k+1].at - obs_q[k].at !== TO + 1 || obs_q[k+1].b !== {24'h0, init_bytes[k+1]})
        $display("[TB] FAIL timeout_step%0d: got gap %0d b=%h expected gap %0d b=%h",
                 k, obs_q[k+1].at - obs_q[k].at, obs_q[k+1].b, TO + 1, init_bytes[k+1]);
      else passed++;
    end
    while (!init_done && n < 100) begin
      tick(1);
      n++;
    end
    tick(10);
    checks++;
    if (!ok || init_done !== 1'b1 || timeout_err !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL timeout_sticky: starts=%0d init_done=%b terr=%b busy=%b expected 4/1/1/0", obs_q.size(), init_done, timeout_err, busy);
    else passed++;
    reset_n = 1'b0;
    tick(1);
    checks++;
    if (timeout_err !== 1'b0) $display("[TB] FAIL timeout_cleared: got %b expected 0", timeout_err);
    else passed++;
    dead    = 1'b0;
    reset_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "[TB] time limit");
  end

  initial begin
    test_reset();
    test_init();
    test_single_cmd();
    test_spurious_done();
    test_back_to_back_full();
    test_random_stream();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
